// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream input and IM write port of the program loader
interface im_loader_if #(parameter int ADDR_W = 12);
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_last;
  logic byte_ready;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;
  modport master (input byte_in, byte_valid, byte_last, output byte_ready, we, waddr, wdata);
  modport slave (output byte_in, byte_valid, byte_last, input byte_ready, we, waddr, wdata);
endinterface

// File: rtl/im_loader.sv
// im_loader: packs a big-endian byte stream into 32-bit IM write strobes and holds the CPU while loading.
// Define IM_LOADER_CKSUM_EN to add a running sum of the written words on cksum.
module im_loader #(
  parameter int ADDR_W = 12,
  parameter int MAX_WORDS = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  im_loader_if.master bus,
  output logic [10:0] word_cnt,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic cpu_hold,
  output logic [31:0] cksum
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] lane;
  logic [31:0] shreg;
  logic last_f;
  logic [ADDR_W-1:0] waddr;
  logic launch, acc, full;
  assign launch = (state == IDLE || state == DONE) && start;
  assign acc = bus.byte_valid && bus.byte_ready;
  assign full = word_cnt == 11'(MAX_WORDS);
  assign bus.byte_ready = state == COLLECT;
  assign bus.we = state == WRITE;
  assign bus.waddr = waddr;
  assign bus.wdata = shreg;
  assign busy = state == COLLECT || state == WRITE;
  assign done = state == DONE;
  assign cpu_hold = busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (launch) state_n = COLLECT;
    else if (state == COLLECT && acc)
      state_n = full ? (bus.byte_last ? DONE : COLLECT) : ((lane == 2'd3 || bus.byte_last) ? WRITE : COLLECT);
    else if (state == WRITE) state_n = last_f ? DONE : COLLECT;
  end
  // Bytes land at lane offset (3-lane)*8, so a short final word is zero-padded low.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_cnt <= '0;
      waddr <= '0;
      lane <= '0;
      shreg <= '0;
      last_f <= 1'b0;
      overflow <= 1'b0;
    end else if (launch) begin
      word_cnt <= '0;
      waddr <= '0;
      lane <= '0;
      shreg <= '0;
      last_f <= 1'b0;
      overflow <= 1'b0;
    end else if (state == COLLECT && acc) begin
      if (full) overflow <= 1'b1;
      else begin
        shreg <= shreg | ({24'h0, bus.byte_in} << {~lane, 3'b000});
        lane <= lane + 2'd1;
        last_f <= bus.byte_last;
      end
    end else if (state == WRITE) begin
      word_cnt <= full ? word_cnt : word_cnt + 11'd1;
      waddr <= waddr + ADDR_W'(4);
      lane <= '0;
      shreg <= '0;
    end
`ifdef IM_LOADER_CKSUM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) cksum <= '0;
    else if (launch) cksum <= '0;
    else if (state == WRITE) cksum <= cksum + shreg;
`else
  assign cksum = '0;
`endif
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for im_loader; dut0 uses default capacity, dut1 has MAX_WORDS=2.
module tb_im_loader;
  logic clk = 0, rst = 1, start = 0, valid = 0, last = 0, sel = 0;
  logic [7:0] b = 0;
  logic [10:0] wc0, wc1;
  logic busy0, busy1, done0, done1, ovf0, ovf1, hold0, hold1;
  logic [31:0] cks0, cks1, cks_model;
  int tests = 0, fails = 0, stalls = 0;
  typedef struct { bit d; logic [11:0] a; logic [31:0] w; } wr_t;
  wr_t q[$];
  always #5 clk = ~clk;
  im_loader_if #(.ADDR_W(12)) bus0 ();
  im_loader_if #(.ADDR_W(12)) bus1 ();
  assign bus0.byte_in = b;
  assign bus1.byte_in = b;
  assign bus0.byte_last = last;
  assign bus1.byte_last = last;
  assign bus0.byte_valid = valid & ~sel;
  assign bus1.byte_valid = valid & sel;
  im_loader dut0 (.clk(clk), .rst(rst), .start(start & ~sel), .bus(bus0), .word_cnt(wc0),
    .busy(busy0), .done(done0), .overflow(ovf0), .cpu_hold(hold0), .cksum(cks0));
  im_loader #(.ADDR_W(12), .MAX_WORDS(2)) dut1 (.clk(clk), .rst(rst), .start(start & sel), .bus(bus1),
    .word_cnt(wc1), .busy(busy1), .done(done1), .overflow(ovf1), .cpu_hold(hold1), .cksum(cks1));
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic mon(input bit d, input logic [11:0] a, input logic [31:0] w);
    wr_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_write: dut%0d got addr %h data %h expected none", d, a, w);
    end else begin
      e = q.pop_front();
      ck("wr_dut", 32'(d), 32'(e.d));
      ck("wr_addr", 32'(a), 32'(e.a));
      ck("wr_data", w, e.w);
    end
  endtask
  always @(negedge clk) begin
    if (bus0.we) mon(0, bus0.waddr, bus0.wdata);
    if (bus1.we) mon(1, bus1.waddr, bus1.wdata);
    if (!sel && valid && busy0 && !bus0.byte_ready) stalls++;
  end
  function automatic logic [31:0] exp_cks();
`ifdef IM_LOADER_CKSUM_EN
    return cks_model;
`else
    return 32'h0;
`endif
  endfunction
  task automatic push(input bit d, input logic [11:0] a, input logic [31:0] w);
    wr_t e;
    e.d = d; e.a = a; e.w = w;
    q.push_back(e);
    cks_model += w;
  endtask
  task automatic do_start();
    @(negedge clk) start = 1;
    @(posedge clk) #1 start = 0;
    cks_model = 0;
    stalls = 0;
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    b = d; last = l; valid = 1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (sel ? bus1.byte_ready : bus0.byte_ready) break;
      if (n > 50) begin
        tests++; fails++;
        $display("FAIL ready_timeout: got byte_ready 0 expected 1");
        break;
      end
    end
    @(posedge clk) #1;
  endtask
  task automatic wait_done();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sel ? done1 : done0) break;
    end
    valid = 0; last = 0;
    ck("done", 32'(sel ? done1 : done0), 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    ck("rst_ready", 32'(bus0.byte_ready), 0);
    ck("rst_busy", 32'(busy0), 0);
    ck("rst_wcnt", 32'(wc0), 0);
    @(negedge clk) rst = 0;
    // reset mid-load after two bytes: no write may appear
    do_start();
    ck("hold_during_load", 32'(hold0), 1);
    send(8'h11, 0);
    send(8'h22, 0);
    valid = 0;
    @(negedge clk) rst = 1;
    #1;
    ck("mid_ready", 32'(bus0.byte_ready), 0);
    ck("mid_we", 32'(bus0.we), 0);
    ck("mid_waddr", 32'(bus0.waddr), 0);
    ck("mid_wdata", bus0.wdata, 0);
    ck("mid_wcnt", 32'(wc0), 0);
    ck("mid_busy", 32'(busy0), 0);
    ck("mid_done", 32'(done0), 0);
    ck("mid_ovf", 32'(ovf0), 0);
    ck("mid_cksum", cks0, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    // two full words
    do_start();
    push(0, 12'h000, 32'h24010005);
    push(0, 12'h004, 32'h8C020000);
    send(8'h24, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h8C, 0); send(8'h02, 0); send(8'h00, 0); send(8'h00, 1);
    wait_done();
    ck("two_wcnt", 32'(wc0), 2);
    ck("two_hold", 32'(hold0), 0);
    ck("two_busy", 32'(busy0), 0);
    ck("two_ovf", 32'(ovf0), 0);
    ck("two_cksum", cks0, exp_cks());
    // partial word
    do_start();
    push(0, 12'h000, 32'h12345600);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 1);
    wait_done();
    ck("part_wcnt", 32'(wc0), 1);
    ck("part_cksum", cks0, exp_cks());
    // continuous valid over 8 words: one stall per word
    do_start();
    for (int i = 0; i < 8; i++)
      push(0, 12'(i * 4), {8'(i * 16), 8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)});
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) send(8'(i * 16 + k), 1'(i == 7 && k == 3));
    wait_done();
    ck("bp_stalls", stalls, 8);
    ck("bp_wcnt", 32'(wc0), 8);
    ck("bp_cksum", cks0, exp_cks());
    // overflow on the 2-word instance
    sel = 1;
    do_start();
    push(1, 12'h000, 32'hA0A1A2A3);
    push(1, 12'h004, 32'hA4A5A6A7);
    for (int i = 0; i < 9; i++) send(8'(8'hA0 + i), 1'(i == 8));
    wait_done();
    ck("ovf_flag", 32'(ovf1), 1);
    ck("ovf_wcnt", 32'(wc1), 2);
    ck("ovf_cksum", cks1, exp_cks());
    sel = 0;
    // checksum wraps to zero
    do_start();
    push(0, 12'h000, 32'h00000001);
    push(0, 12'h004, 32'hFFFFFFFF);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 1);
    wait_done();
    ck("cks_wcnt", 32'(wc0), 2);
    ck("cks_value", cks0, exp_cks());
    repeat (3) @(negedge clk);
    ck("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the 4 KB instruction memory: receives a program as a byte stream and emits word-aligned 32-bit write strobes into a writable IM port.
- Sits between a byte source (UART receiver or testbench) and the IM write port.
- Holds the CPU in reset through cpu_hold while loading.
- IM addressing is byte addresses; the word index is addr/4.

Parameters:
- ADDR_W, 12, width of the IM byte address (4 KB space).
- MAX_WORDS, 1024, capacity in 32-bit words; must be ≤ 2^(ADDR_W-2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session.
- byte_in  in  8  incoming program byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  qualifies byte_in as the final program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  one-cycle IM write strobe.
- waddr  out  ADDR_W  IM byte address of the write; bits [1:0] always 0.
- wdata  out  32  instruction word to write.
- word_cnt  out  11  words written this session.
- busy  out  1  a session is active.
- done  out  1  session completed; level signal.
- overflow  out  1  a byte arrived after MAX_WORDS words were written; sticky.
- cpu_hold  out  1  holds the CPU reset; equals busy.
- cksum  out  32  running checksum (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state IDLE. byte_ready=0, we=0, waddr=0, wdata=0, word_cnt=0, busy=0, done=0, overflow=0, cksum=0. Byte lane counter=0, shift register=0.
- Byte accept: a byte is accepted when byte_valid && byte_ready.
- Byte order: big-endian. The first byte of each group of 4 goes to wdata[31:24], the fourth to [7:0]. This matches the hex-word order of the program image.
- State IDLE:
  - byte_ready=0.
  - start → COLLECT. Clears word_cnt, waddr, lane counter, done, overflow and cksum. Sets busy.
- State COLLECT:
  - byte_ready=1.
  - Each accepted byte is shifted into the assembly register and the lane counter increments.
  - On the 4th byte, or on any byte with byte_last=1 → WRITE. A partial word is zero-padded in its low bytes, e.g. bytes AA,BB with last → 0xAABB0000.
- State WRITE (exactly 1 cycle):
  - byte_ready=0, we=1.
  - wdata = assembled word; waddr = word_cnt×4.
  - Next cycle: word_cnt+1, waddr+4, lane counter=0.
  - If the word was terminated by byte_last → DONE, else → COLLECT.
  - Latency: we is asserted the cycle after the 4th or last byte is accepted.
- State DONE:
  - busy=0, done=1, byte_ready=0.
  - start → restart session as from IDLE.
- Overflow:
  - After MAX_WORDS words are written without byte_last, the loader stays in COLLECT.
  - Any further accepted byte sets overflow and is dropped; no we is issued.
  - A byte with byte_last=1 in this condition → DONE.
- start while busy: ignored.
- byte_valid in IDLE or DONE: not accepted; byte_ready=0.
- rst mid-session: immediate return to reset state, with no partial write emitted.
- word_cnt saturates at MAX_WORDS.
- waddr wraps only through ADDR_W truncation, which is unreachable given the MAX_WORDS limit.
- An empty session (start followed by no bytes) stays in COLLECT indefinitely. There is no timeout.

Optional Feature:
- Macro: IM_LOADER_CKSUM_EN.
- Defined: on every WRITE cycle, cksum <= cksum + wdata (mod 2^32). cksum is cleared on start and on reset, and is stable once done=1.
- Not defined: cksum is tied to 32'h0 and no adder is synthesized.

Test Plan:
- Reset mid-load: rst pulse after 2 accepted bytes → next cycle all outputs are at reset values; no we pulse occurs.
- Two full words: start, bytes 24,01,00,05, 8C,02,00,00 with last on the final byte → we at waddr 0x000 wdata 0x24010005, then waddr 0x004 wdata 0x8C020000; done=1, word_cnt=2, cpu_hold falls with done.
- Partial word: start, bytes 12,34,56 with last on 56 → single write waddr 0x000 wdata 0x12345600; done=1, word_cnt=1.
- Backpressure: byte_valid held high continuously → byte_ready drops for exactly 1 cycle per word (WRITE); no byte is lost or duplicated over 8 words.
- Overflow with MAX_WORDS=2: send 9 bytes with last on the 9th → 2 writes, overflow=1, done=1, word_cnt=2.
- Checksum (IM_LOADER_CKSUM_EN defined): words 0x00000001 and 0xFFFFFFFF → cksum=0x00000000. Without the macro, cksum=0 throughout.
